// File: rtl/pwm_led_bank_if.sv
// pwm_led_bank_if: control/status bundle for the PWM LED bank.
// The master side (command decoder, switches or bench) drives the run enable
// and the write port; the slave side (pwm_led_bank) returns the LED vector
// and the period tick.
interface pwm_led_bank_if #(
    parameter int CH  = 8,
    parameter int RES = 8
) ();
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic           enable;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [RES-1:0] wr_duty;
    logic           wr_mode;
    logic [CH-1:0]  led;
    logic           period_tick;

    modport master (
        output enable, wr_en, wr_ch, wr_duty, wr_mode,
        input  led, period_tick
    );

    modport slave (
        input  enable, wr_en, wr_ch, wr_duty, wr_mode,
        output led, period_tick
    );
endinterface

// File: rtl/pwm_led_bank.sv
// pwm_led_bank: CH-channel PWM LED driver with a shared prescaler and phase
// counter, double-buffered per-channel duty (pending -> active at each period
// boundary, with same-cycle write bypass) and a global run enable.
// Optional feature macro: PWM_BREATHE_EN adds the per-channel breathing ramp
// (level/dir/period counter, paced by BREATH_DIV). Without it every channel
// is static and wr_mode is ignored.
module pwm_led_bank #(
    parameter int CH         = 8,
    parameter int RES        = 8,
    parameter int PRESC      = 196,
    parameter int BREATH_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    pwm_led_bank_if.slave     bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [RES-1:0] PHASE_MAX = '1;

    logic [PW-1:0]  r_pcnt;
    logic [RES-1:0] r_phase;
    logic           r_period_tick;
    logic [CH-1:0]  r_led;
    logic [RES-1:0] r_pend_duty [CH];
    logic [RES-1:0] r_act_duty  [CH];

    logic           w_step;
    logic           w_boundary;
    logic [CH-1:0]  w_wr_hit;
    logic [RES-1:0] w_new_duty  [CH];
    logic [RES-1:0] w_cmp       [CH];

    // enable is folded into step, so nothing advances while the bank is stopped
    assign w_step     = bus.enable && (r_pcnt == PW'(PRESC - 1));
    assign w_boundary = w_step && (r_phase == PHASE_MAX);

    // Prescaler and phase counter; both held at zero while disabled
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pcnt  <= '0;
            r_phase <= '0;
        end else if (!bus.enable) begin
            r_pcnt  <= '0;
            r_phase <= '0;
        end else if (w_step) begin
            r_pcnt  <= '0;
            r_phase <= r_phase + 1'b1;
        end else begin
            r_pcnt  <= r_pcnt + 1'b1;
        end
    end

    // Period tick is the boundary delayed by one cycle, aligned with new active values
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_period_tick <= 1'b0;
        else        r_period_tick <= w_boundary;
    end

    // Write decode and the value each channel loads at the boundary (write bypass wins)
    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_wr_hit[i]   = 1'b0;
            w_new_duty[i] = r_pend_duty[i];
            if (bus.wr_en && (bus.wr_ch == CW'(i))) begin
                w_wr_hit[i]   = 1'b1;
                w_new_duty[i] = bus.wr_duty;
            end
        end
    end

    // Pending duty takes writes at any time; active duty copies it at each boundary
    // NOTE: the per-channel register arrays are small flops, so all of them take the async reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CH; i++) begin
                r_pend_duty[i] <= '0;
                r_act_duty[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_wr_hit[i]) r_pend_duty[i] <= bus.wr_duty;
                if (w_boundary)  r_act_duty[i]  <= w_new_duty[i];
            end
        end
    end

`ifdef PWM_BREATHE_EN
    localparam int BW = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;

    logic [CH-1:0]  r_pend_mode;
    logic [CH-1:0]  r_act_mode;
    logic [CH-1:0]  r_dir_down;
    logic [RES-1:0] r_level [CH];
    logic [BW-1:0]  r_bcnt  [CH];
    logic [CH-1:0]  w_new_mode;

    // Mode value each channel loads at the boundary, with the same write bypass as duty
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_new_mode[i] = w_wr_hit[i] ? bus.wr_mode : r_pend_mode[i];
        end
    end

    // Mode registers and the breathing ramp; the ramp only moves on boundaries
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend_mode <= '0;
            r_act_mode  <= '0;
            r_dir_down  <= '0;
            for (int i = 0; i < CH; i++) begin
                r_level[i] <= '0;
                r_bcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_wr_hit[i]) r_pend_mode[i] <= bus.wr_mode;
                if (w_boundary) begin
                    r_act_mode[i] <= w_new_mode[i];
                    if (!w_new_mode[i] || !r_act_mode[i]) begin
                        // static channel, or entering breathe: restart the ramp from the bottom
                        r_level[i]    <= '0;
                        r_dir_down[i] <= 1'b0;
                        r_bcnt[i]     <= '0;
                    end else if (w_new_duty[i] < r_level[i]) begin
                        // peak lowered below the current level: clamp and head down
                        r_level[i]    <= w_new_duty[i];
                        r_dir_down[i] <= 1'b1;
                    end else if (r_bcnt[i] == BW'(BREATH_DIV - 1)) begin
                        r_bcnt[i] <= '0;
                        if (!r_dir_down[i]) begin
                            if (r_level[i] < w_new_duty[i]) begin
                                r_level[i] <= r_level[i] + 1'b1;
                                if ((r_level[i] + 1'b1) == w_new_duty[i]) r_dir_down[i] <= 1'b1;
                            end else begin
                                r_dir_down[i] <= 1'b1;
                            end
                        end else begin
                            if (r_level[i] != '0) begin
                                r_level[i] <= r_level[i] - 1'b1;
                                if (r_level[i] == RES'(1)) r_dir_down[i] <= 1'b0;
                            end else begin
                                r_dir_down[i] <= 1'b0;
                            end
                        end
                    end else begin
                        r_bcnt[i] <= r_bcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Breathing channels compare against their level, static ones against the duty
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_cmp[i] = r_act_mode[i] ? r_level[i] : r_act_duty[i];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{bus.wr_mode, BREATH_DIV};

    // Every channel is static
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_cmp[i] = r_act_duty[i];
        end
    end
`endif

    // Registered LED outputs, forced off while disabled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_led <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_led[i] <= bus.enable && (r_phase < w_cmp[i]);
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.period_tick = r_period_tick;

endmodule
